gcd_sequencer: RTL

Upstream control stage for the gcd core. Accepts operand pairs on a valid/ready stream and issues each pair to the core with a one-cycle enable. It waits for the core's result, then presents that result downstream on a valid/ready stream. Also short-circuits zero operands, bounds core latency with a timeout, and reports per-operation cycle count.

---
 rtl/gcd_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: upstream control stage for the gcd core.
// Streams operand pairs in, issues them to the core, streams results out.
module gcd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  out_cycles,
  output logic                  gcd_enable,
  output logic [DATA_WIDTH-1:0] gcd_a,
  output logic [DATA_WIDTH-1:0] gcd_b,
  input  logic                  gcd_valid,
  input  logic [DATA_WIDTH-1:0] gcd_y,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t state_q;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] a_nx;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] b_nx;
  logic [DATA_WIDTH-1:0] y_q;
  logic [DATA_WIDTH-1:0] y_nx;
  logic                  err_q;
  logic                  err_nx;
  logic [CNT_WIDTH-1:0]  cyc_q;
  logic [CNT_WIDTH-1:0]  cyc_nx;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_nx;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  zero_op;

  // Counter stops at the timeout value instead of wrapping.
  assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + ONE;

  assign zero_op = (in_a == '0) || (in_b == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Operand, result and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
      cyc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_nx;
      b_q   <= b_nx;
      y_q   <= y_nx;
      err_q <= err_nx;
      cyc_q <= cyc_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Next-state and datapath update decode.
  always_comb begin
    state_nx = state_q;
    a_nx     = a_q;
    b_nx     = b_q;
    y_nx     = y_q;
    err_nx   = err_q;
    cyc_nx   = cyc_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_nx = in_a;
          b_nx = in_b;
          if (zero_op) begin
            y_nx     = in_a | in_b;
            err_nx   = 1'b0;
            cyc_nx   = '0;
            state_nx = S_OUT;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_nx   = ONE;
        state_nx = S_ARM;
      end
      S_ARM: begin
        // A stale gcd_valid from the last op may still be high here.
        cnt_nx   = cnt_inc;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        cnt_nx = cnt_inc;
        if (gcd_valid) begin
          y_nx     = gcd_y;
          err_nx   = 1'b0;
          cyc_nx   = cnt_q;
          state_nx = S_OUT;
        end else if (cnt_q == TMO) begin
          y_nx     = '0;
          err_nx   = 1'b1;
          cyc_nx   = TMO;
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign gcd_enable = (state_q == S_ISSUE);
  assign out_valid  = (state_q == S_OUT);
  assign gcd_a      = a_q;
  assign gcd_b      = b_q;
  assign out_y      = y_q;
  assign out_err    = err_q;
  assign out_cycles = cyc_q;

endmodule
